// File: rtl/mmio_uart_tx_pkg.sv
// Shared types and constants for the memory-mapped UART transmit port.
package mmio_uart_tx_pkg;

   // Store address that routes data to the UART instead of memory
   localparam logic [15:0] MMIO_TX_ADDR = 16'hABCD;

   // UART frame sequencer states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_e;

   // Occupancy counter width: must hold 0..depth inclusive
   function automatic int unsigned lvl_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Store-side bus from the control unit / ALU into the MMIO UART port.
interface mmio_uart_tx_if;
   logic        st_en;
   logic        abcd_hit;
   logic        st_byte;
   logic [31:0] st_data;
   logic        stall;

   modport master (output st_en, abcd_hit, st_byte, st_data, input stall);
   modport slave  (input st_en, abcd_hit, st_byte, st_data, output stall);
endinterface

// File: rtl/mmio_uart_tx_byte_fifo.sv
// Byte FIFO with a 1-or-4 byte write port and a single-byte read port.
module mmio_uart_tx_byte_fifo
   import mmio_uart_tx_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      wr_en_i,
   input  logic                      wr_quad_i,
   input  logic [31:0]               wr_data_i,
   input  logic                      rd_en_i,
   output logic [7:0]                rd_data_o,
   output logic [lvl_w(DEPTH)-1:0]   level_o
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = lvl_w(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wp1_c, wp2_c, wp3_c;
   logic [LW-1:0] level_q, level_d;
   logic          rd_c;

   // Pointer and occupancy next-state; reads from an empty FIFO are dropped
   always_comb begin
      rd_c     = rd_en_i & (level_q != '0);
      wp1_c    = AW'(wr_ptr_q + AW'(1));
      wp2_c    = AW'(wr_ptr_q + AW'(2));
      wp3_c    = AW'(wr_ptr_q + AW'(3));
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (wr_en_i) begin
         wr_ptr_d = wr_quad_i ? AW'(wr_ptr_q + AW'(4)) : wp1_c;
         level_d  = LW'(level_d + (wr_quad_i ? LW'(4) : LW'(1)));
      end
      if (rd_c) begin
         rd_ptr_d = AW'(rd_ptr_q + AW'(1));
         level_d  = LW'(level_d - LW'(1));
      end
   end

   // Storage: a word store lands MSB byte first so it is transmitted first
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         if (wr_quad_i) begin
            mem_q[wr_ptr_q] <= wr_data_i[31:24];
            mem_q[wp1_c]    <= wr_data_i[23:16];
            mem_q[wp2_c]    <= wr_data_i[15:8];
            mem_q[wp3_c]    <= wr_data_i[7:0];
         end else begin
            mem_q[wr_ptr_q] <= wr_data_i[7:0];
         end
      end
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   assign rd_data_o = mem_q[rd_ptr_q];
   assign level_o   = level_q;

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter: queues stores to 0xABCD and sends them 8N1.
module mmio_uart_tx
   import mmio_uart_tx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned FIFO_DEPTH   = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   mmio_uart_tx_if.slave                 st,
   output logic                          tx,
   output logic                          busy,
   output logic [lvl_w(FIFO_DEPTH)-1:0]  level
);
   localparam int unsigned LW = lvl_w(FIFO_DEPTH);
   localparam int unsigned BW = $clog2(CLKS_PER_BIT);

   logic          hit_c, fits_c, acc_c, pop_c, baud_done_c;
   logic [LW-1:0] need_c, free_c;
   logic [7:0]    rd_byte;

   uart_state_e   state_q;
   logic [BW-1:0] baud_q;
   logic [2:0]    bit_q;
   logic [7:0]    shift_q;
   logic          tx_q;

   // Accept/stall decision uses the current level, ignoring a same-cycle pop
   always_comb begin
      hit_c       = st.st_en & st.abcd_hit;
      need_c      = st.st_byte ? LW'(1) : LW'(4);
      free_c      = LW'(LW'(FIFO_DEPTH) - level);
      fits_c      = (free_c >= need_c);
      acc_c       = hit_c & fits_c;
      baud_done_c = (baud_q == BW'(CLKS_PER_BIT - 1));
      pop_c       = (level != '0) &
                    ((state_q == ST_IDLE) | ((state_q == ST_STOP) & baud_done_c));
   end

   assign st.stall = hit_c & ~fits_c;

   mmio_uart_tx_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en_i   (acc_c),
      .wr_quad_i (~st.st_byte),
      .wr_data_i (st.st_data),
      .rd_en_i   (pop_c),
      .rd_data_o (rd_byte),
      .level_o   (level)
   );

   // Frame sequencer; tx is registered alongside the state so it tracks it exactly
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pop_c) begin
                  state_q <= ST_START;
                  baud_q  <= '0;
                  shift_q <= rd_byte;
                  tx_q    <= 1'b0;
               end
            end
            ST_START: begin
               if (baud_done_c) begin
                  state_q <= ST_DATA;
                  baud_q  <= '0;
                  bit_q   <= '0;
                  tx_q    <= shift_q[0];
               end else begin
                  baud_q <= BW'(baud_q + BW'(1));
               end
            end
            ST_DATA: begin
               if (baud_done_c) begin
                  baud_q  <= '0;
                  shift_q <= {1'b0, shift_q[7:1]};
                  if (bit_q == 3'd7) begin
                     state_q <= ST_STOP;
                     tx_q    <= 1'b1;
                  end else begin
                     bit_q <= 3'(bit_q + 3'd1);
                     tx_q  <= shift_q[1];
                  end
               end else begin
                  baud_q <= BW'(baud_q + BW'(1));
               end
            end
            ST_STOP: begin
               if (baud_done_c) begin
                  baud_q <= '0;
                  if (pop_c) begin
                     state_q <= ST_START;
                     shift_q <= rd_byte;
                     tx_q    <= 1'b0;
                  end else begin
                     state_q <= ST_IDLE;
                     tx_q    <= 1'b1;
                  end
               end else begin
                  baud_q <= BW'(baud_q + BW'(1));
               end
            end
            default: begin
               state_q <= ST_IDLE;
               tx_q    <= 1'b1;
            end
         endcase
      end
   end

   assign tx   = tx_q;
   assign busy = (level != '0) | (state_q != ST_IDLE);

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: stores push expected bytes, a tx monitor checks frames.
module tb_mmio_uart_tx;
   import mmio_uart_tx_pkg::*;

   localparam int unsigned CPB   = 4;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned LW    = lvl_w(DEPTH);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          tx, busy;
   logic [LW-1:0] level;

   mmio_uart_tx_if bus ();

   mmio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .st    (bus),
      .tx    (tx),
      .busy  (busy),
      .level (level)
   );

   always #5 clk = ~clk;

   int         n_checks    = 0;
   int         n_errs      = 0;
   int         cyc         = 0;
   int         frames_done = 0;
   bit         mon_on      = 1'b0;
   logic [7:0] exp_q[$];
   int         start_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Drive one store at a negedge, hold it while stalled, push its expected bytes on accept
   task automatic store(input logic [15:0] addr, input logic is_sb, input logic [31:0] data,
                        input int nexp, input logic [7:0] e0, input logic [7:0] e1,
                        input logic [7:0] e2, input logic [7:0] e3, output int stalls);
      logic [7:0] ev [4];
      ev = '{e0, e1, e2, e3};
      stalls = 0;
      bus.st_en    = 1'b1;
      bus.abcd_hit = (addr == MMIO_TX_ADDR);
      bus.st_byte  = is_sb;
      bus.st_data  = data;
      #1;
      while (bus.stall === 1'b1 && stalls < 1000) begin
         stalls++;
         @(negedge clk);
         #1;
      end
      for (int i = 0; i < nexp; i++) exp_q.push_back(ev[i]);
      @(posedge clk);
      @(negedge clk);
      bus.st_en    = 1'b0;
      bus.abcd_hit = 1'b0;
   endtask

   task automatic wait_idle(input int maxc, output int n);
      n = 0;
      while (busy !== 1'b0 && n < maxc) begin
         @(negedge clk);
         n++;
      end
   endtask

   // Frame monitor: on a start bit, pop the expected byte and check every bit cell
   initial begin
      logic [9:0] fr;
      bit         ok, abort;
      forever begin
         @(negedge clk);
         if (mon_on && tx === 1'b0) begin
            start_q.push_back(cyc);
            chk("frame_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) fr = {1'b1, exp_q.pop_front(), 1'b0};
            else                   fr = 10'h3FE;
            abort = 1'b0;
            for (int b = 0; b < 10 && !abort; b++) begin
               ok = 1'b1;
               for (int c = 0; c < int'(CPB); c++) begin
                  if (b != 0 || c != 0) @(negedge clk);
                  if (!mon_on) begin
                     abort = 1'b1;
                     break;
                  end
                  if (tx !== fr[b]) ok = 1'b0;
               end
               if (!abort) chk($sformatf("frame_%02h_bit%0d", fr[8:1], b), 32'(ok), 32'd1);
            end
            if (!abort) frames_done++;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int s, n, toggles;
      rst_n        = 1'b0;
      bus.st_en    = 1'b0;
      bus.abcd_hit = 1'b0;
      bus.st_byte  = 1'b0;
      bus.st_data  = '0;
      repeat (3) @(negedge clk);
      chk("reset_tx", 32'(tx), 32'd1);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_level", 32'(level), 32'd0);
      chk("reset_stall", 32'(bus.stall), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      mon_on = 1'b1;

      // Store to a non-UART address is ignored
      store(16'h1000, 1'b0, 32'hFFFF_FFFF, 0, 8'h00, 8'h00, 8'h00, 8'h00, s);
      chk("miss_stall", 32'(s), 32'd0);
      chk("miss_level", 32'(level), 32'd0);
      chk("miss_tx", 32'(tx), 32'd1);
      chk("miss_busy", 32'(busy), 32'd0);

      // Single byte
      store(MMIO_TX_ADDR, 1'b1, 32'h0000_00A5, 1, 8'hA5, 8'h00, 8'h00, 8'h00, s);
      chk("sb_stall", 32'(s), 32'd0);
      chk("sb_level", 32'(level), 32'd1);
      chk("sb_busy", 32'(busy), 32'd1);
      wait_idle(100, n);
      chk("sb_idle_cycles", 32'(n), 32'd41);
      chk("sb_frames", 32'(frames_done), 32'd1);

      // Word: four back-to-back frames, MSB byte first
      start_q.delete();
      store(MMIO_TX_ADDR, 1'b0, 32'h1234_5678, 4, 8'h12, 8'h34, 8'h56, 8'h78, s);
      chk("sw_stall", 32'(s), 32'd0);
      wait_idle(400, n);
      chk("sw_idle_cycles", 32'(n), 32'd161);
      chk("sw_frame_count", 32'(start_q.size()), 32'd4);
      for (int i = 1; i < start_q.size(); i++)
         chk($sformatf("sw_gap%0d", i), 32'(start_q[i] - start_q[i-1]), 32'd40);
      chk("sw_frames", 32'(frames_done), 32'd5);

      // Fill and back-pressure
      store(MMIO_TX_ADDR, 1'b0, 32'h1122_3344, 4, 8'h11, 8'h22, 8'h33, 8'h44, s);
      chk("fill1_stall", 32'(s), 32'd0);
      store(MMIO_TX_ADDR, 1'b0, 32'h5566_7788, 4, 8'h55, 8'h66, 8'h77, 8'h88, s);
      chk("fill2_stall", 32'(s), 32'd0);
      chk("fill2_level", 32'(level), 32'd7);
      store(MMIO_TX_ADDR, 1'b0, 32'h99AA_BBCC, 4, 8'h99, 8'hAA, 8'hBB, 8'hCC, s);
      chk("sw_stall_cycles", 32'(s), 32'd120);
      chk("full_level", 32'(level), 32'd8);
      store(MMIO_TX_ADDR, 1'b1, 32'hDEAD_BE5A, 1, 8'h5A, 8'h00, 8'h00, 8'h00, s);
      chk("sb_stall_cycles", 32'(s), 32'd39);
      wait_idle(1000, n);
      chk("drain_timeout", 32'(n < 1000), 32'd1);
      chk("drain_queue", 32'(exp_q.size()), 32'd0);
      chk("drain_frames", 32'(frames_done), 32'd18);

      // Reset in the middle of a frame
      store(MMIO_TX_ADDR, 1'b1, 32'h0000_00C3, 1, 8'hC3, 8'h00, 8'h00, 8'h00, s);
      repeat (10) @(negedge clk);
      chk("mid_busy", 32'(busy), 32'd1);
      mon_on = 1'b0;
      rst_n  = 1'b0;
      @(negedge clk);
      chk("rst_mid_tx", 32'(tx), 32'd1);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      chk("rst_mid_level", 32'(level), 32'd0);
      repeat (2) @(negedge clk);
      rst_n   = 1'b1;
      toggles = 0;
      repeat (50) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) toggles++;
      end
      chk("post_rst_quiet", 32'(toggles), 32'd0);
      chk("post_rst_queue", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
